sargantana_itag_array: RTL and testbench

Parametrised instruction-cache tag/valid array with a built-in hit comparator and a multi-cycle walked flush. It sits between the icache controller and the tag storage. It returns per-way tags, valid bits and a registered hit vector one cycle after a lookup. Way count, tag width and set count are parameters. The valid array is a set-indexed storage word, so reset and flush clear it by walking one set per cycle, with back-pressure to the controller while clearing.

---
 rtl/sargantana_itag_array.sv | 124 ++++++++++++
 tb/tb_sargantana_itag_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_itag_array.sv
// Instruction-cache tag/valid array with registered per-way hit compare and a walked valid clear.
// Lookup results appear one cycle after acceptance; the array refuses accesses while the clear walk runs.
module sargantana_itag_array #(
  parameter int unsigned N_WAY  = 4,
  parameter int unsigned TAG_W  = 27,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_WAY-1:0]       req_i,
  input  logic                   we_i,
  input  logic                   vbit_i,
  input  logic                   flush_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic [TAG_W-1:0]       cmp_tag_i,
  output logic                   ready_o,
  output logic                   flush_busy_o,
  output logic                   rvalid_o,
  output logic [N_WAY*TAG_W-1:0] tag_way_o,
  output logic [N_WAY-1:0]       vbit_o,
  output logic [N_WAY-1:0]       hit_way_o,
  output logic                   hit_o
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_cnt;
  logic [N_WAY*TAG_W-1:0] r_tag_mem [DEPTH];
  logic [N_WAY-1:0]       r_vld_mem [DEPTH];

  logic                   r_rvalid;
  logic [N_WAY*TAG_W-1:0] r_tag_way;
  logic [N_WAY-1:0]       r_vbit;
  logic [N_WAY-1:0]       r_hit_way;
  logic                   r_hit;

  logic                   w_ready;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_flush_start;
  logic [N_WAY*TAG_W-1:0] w_tag_rd;
  logic [N_WAY*TAG_W-1:0] w_tag_wr;
  logic [N_WAY-1:0]       w_vld_rd;
  logic [N_WAY-1:0]       w_vld_wr;
  logic [N_WAY-1:0]       w_vbit_rd;
  logic [N_WAY-1:0]       w_hit_rd;

  // A flush request outranks any access presented in the same cycle.
  assign w_ready       = (r_state == S_IDLE) && !flush_i;
  assign w_wr          = w_ready && (|req_i) && we_i;
  assign w_rd          = w_ready && (|req_i) && !we_i;
  assign w_flush_start = (r_state == S_IDLE) && flush_i;

  assign w_tag_rd  = r_tag_mem[addr_i];
  assign w_vld_rd  = r_vld_mem[addr_i];
  assign w_vld_wr  = (w_vld_rd & ~req_i) | ({N_WAY{vbit_i}} & req_i);
  assign w_vbit_rd = w_vld_rd & req_i;

  always_comb begin
    w_tag_wr = w_tag_rd;
    w_hit_rd = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (req_i[w]) w_tag_wr[w*TAG_W +: TAG_W] = tag_i;
      w_hit_rd[w] = w_vbit_rd[w] && (w_tag_rd[w*TAG_W +: TAG_W] == cmp_tag_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_tag_mem[addr_i] <= w_tag_wr;
  end

  // Valid storage has no reset of its own; the walk is what clears it.
  always_ff @(posedge clk_i) begin
    if (r_state == S_CLEAR) r_vld_mem[r_cnt] <= '0;
    else if (w_wr)          r_vld_mem[addr_i] <= w_vld_wr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_IDLE;
      else                             r_cnt   <= r_cnt + 1'b1;
    end else if (flush_i) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid  <= 1'b0;
      r_tag_way <= '0;
      r_vbit    <= '0;
      r_hit_way <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_tag_way <= w_tag_rd;
        r_vbit    <= w_vbit_rd;
        r_hit_way <= w_hit_rd;
        r_hit     <= |w_hit_rd;
      end else if (w_flush_start) begin
        r_vbit    <= '0;
        r_hit_way <= '0;
        r_hit     <= 1'b0;
      end
    end
  end

  assign ready_o      = w_ready;
  assign flush_busy_o = (r_state == S_CLEAR);
  assign rvalid_o     = r_rvalid;
  assign tag_way_o    = r_tag_way;
  assign vbit_o       = r_vbit;
  assign hit_way_o    = r_hit_way;
  assign hit_o        = r_hit;

endmodule

// File: tb/tb_sargantana_itag_array.sv
// Directed bench for sargantana_itag_array: reset walk, write/lookup hits, flush, reset mid-walk.
module tb_sargantana_itag_array;
  localparam int N_WAY  = 4;
  localparam int TAG_W  = 27;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N_WAY-1:0]       req_i;
  logic                   we_i;
  logic                   vbit_i;
  logic                   flush_i;
  logic [ADDR_W-1:0]      addr_i;
  logic [TAG_W-1:0]       tag_i;
  logic [TAG_W-1:0]       cmp_tag_i;
  logic                   ready_o;
  logic                   flush_busy_o;
  logic                   rvalid_o;
  logic [N_WAY*TAG_W-1:0] tag_way_o;
  logic [N_WAY-1:0]       vbit_o;
  logic [N_WAY-1:0]       hit_way_o;
  logic                   hit_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sargantana_itag_array #(.N_WAY(N_WAY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .vbit_i(vbit_i),
    .flush_i(flush_i), .addr_i(addr_i), .tag_i(tag_i), .cmp_tag_i(cmp_tag_i),
    .ready_o(ready_o), .flush_busy_o(flush_busy_o), .rvalid_o(rvalid_o),
    .tag_way_o(tag_way_o), .vbit_o(vbit_o), .hit_way_o(hit_way_o), .hit_o(hit_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_i = '0; we_i = 1'b0; vbit_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                          input logic v, input logic [N_WAY-1:0] r);
    addr_i = a; tag_i = t; vbit_i = v; req_i = r; we_i = 1'b1;
    tick();
    idle_in();
  endtask

  // Leaves the bench in the response cycle of the lookup.
  task automatic do_lookup(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] c,
                           input logic [N_WAY-1:0] r);
    addr_i = a; cmp_tag_i = c; req_i = r; we_i = 1'b0;
    tick();
    idle_in();
  endtask

  task automatic test_reset();
    int n;
    rst_i = 1'b1; idle_in(); req_i = 4'hF; addr_i = 7'd5; cmp_tag_i = '0; tag_i = '0;
    repeat (3) tick();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", ready_o); end
    checks++; if (flush_busy_o !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b want 1", flush_busy_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b want 0", rvalid_o); end
    checks++; if (vbit_o !== 4'h0 || hit_way_o !== 4'h0 || hit_o !== 1'b0) begin
      errors++; $display("FAIL rst_vbit_hit got %h/%h/%0b want 0/0/0", vbit_o, hit_way_o, hit_o); end
    checks++; if (tag_way_o !== '0) begin errors++; $display("FAIL rst_tag got %h want 0", tag_way_o); end
    rst_i = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL rst_walk_len got %0d want %0d", n, DEPTH); end
    // req_i=F still held, so this edge accepts a lookup of set 5.
    tick();
    req_i = '0;
    checks++; if (rvalid_o !== 1'b1 || vbit_o !== 4'h0 || hit_o !== 1'b0) begin
      errors++; $display("FAIL post_rst_lookup got rv=%0b v=%h h=%0b want 1/0/0", rvalid_o, vbit_o, hit_o); end
    tick();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %0b want 0", rvalid_o); end
  endtask

  task automatic test_write_hit();
    logic [TAG_W-1:0] t;
    do_write(7'd3, 27'h1234567, 1'b1, 4'b0100);
    do_lookup(7'd3, 27'h1234567, 4'hF);
    t = tag_way_o[2*TAG_W +: TAG_W];
    checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL wh_rvalid got %0b want 1", rvalid_o); end
    checks++; if (vbit_o !== 4'b0100) begin errors++; $display("FAIL wh_vbit got %b want 0100", vbit_o); end
    checks++; if (hit_way_o !== 4'b0100 || hit_o !== 1'b1) begin
      errors++; $display("FAIL wh_hit got %b/%0b want 0100/1", hit_way_o, hit_o); end
    checks++; if (t !== 27'h1234567) begin errors++; $display("FAIL wh_tag2 got %h want 1234567", t); end
    tick();
    checks++; if (rvalid_o !== 1'b0 || vbit_o !== 4'b0100 || hit_o !== 1'b1) begin
      errors++; $display("FAIL wh_hold got rv=%0b v=%b h=%0b want 0/0100/1", rvalid_o, vbit_o, hit_o); end
  endtask

  task automatic test_miss();
    do_lookup(7'd3, 27'h1234566, 4'hF);
    checks++; if (hit_o !== 1'b0 || hit_way_o !== 4'h0 || vbit_o !== 4'b0100) begin
      errors++; $display("FAIL miss_tag got h=%0b hw=%b v=%b want 0/0000/0100", hit_o, hit_way_o, vbit_o); end
    do_lookup(7'd3, 27'h1234567, 4'b1011);
    checks++; if (vbit_o !== 4'h0 || hit_o !== 1'b0) begin
      errors++; $display("FAIL miss_mask got v=%b h=%0b want 0000/0", vbit_o, hit_o); end
  endtask

  task automatic test_multi_back_to_back();
    logic [TAG_W-1:0] t;
    do_write(7'd9, 27'h0ABCDEF, 1'b1, 4'b0011);
    do_write(7'd10, 27'h7654321, 1'b1, 4'b1000);
    do_lookup(7'd9, 27'h0ABCDEF, 4'hF);
    checks++; if (hit_way_o !== 4'b0011 || hit_o !== 1'b1) begin
      errors++; $display("FAIL multi_hit got %b/%0b want 0011/1", hit_way_o, hit_o); end
    addr_i = 7'd9; cmp_tag_i = 27'h0ABCDEF; req_i = 4'hF; we_i = 1'b0;
    tick();
    checks++; if (rvalid_o !== 1'b1 || vbit_o !== 4'b0011 || hit_way_o !== 4'b0011) begin
      errors++; $display("FAIL b2b_first got rv=%0b v=%b hw=%b want 1/0011/0011", rvalid_o, vbit_o, hit_way_o); end
    addr_i = 7'd10; cmp_tag_i = 27'h7654321;
    tick();
    idle_in();
    t = tag_way_o[3*TAG_W +: TAG_W];
    checks++; if (rvalid_o !== 1'b1 || vbit_o !== 4'b1000 || hit_way_o !== 4'b1000 || t !== 27'h7654321) begin
      errors++; $display("FAIL b2b_second got rv=%0b v=%b hw=%b t=%h want 1/1000/1000/7654321",
                         rvalid_o, vbit_o, hit_way_o, t); end
    tick();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b want 0", rvalid_o); end
  endtask

  task automatic test_flush();
    int n;
    do_write(7'd127, 27'h5A5A5A5, 1'b1, 4'hF);
    do_lookup(7'd127, 27'h5A5A5A5, 4'hF);
    // Response cycle of that lookup doubles as the flush-entry cycle, with a new lookup offered.
    flush_i = 1'b1; req_i = 4'hF; we_i = 1'b0; addr_i = 7'd127;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL fl_ready got %0b want 0", ready_o); end
    checks++; if (rvalid_o !== 1'b1 || vbit_o !== 4'hF || hit_o !== 1'b1) begin
      errors++; $display("FAIL fl_preflush got rv=%0b v=%h h=%0b want 1/F/1", rvalid_o, vbit_o, hit_o); end
    tick();
    idle_in();
    checks++; if (rvalid_o !== 1'b0 || flush_busy_o !== 1'b1) begin
      errors++; $display("FAIL fl_drop got rv=%0b busy=%0b want 0/1", rvalid_o, flush_busy_o); end
    checks++; if (vbit_o !== 4'h0 || hit_way_o !== 4'h0 || hit_o !== 1'b0) begin
      errors++; $display("FAIL fl_force got %h/%h/%0b want 0/0/0", vbit_o, hit_way_o, hit_o); end
    n = 0;
    while (flush_busy_o === 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL fl_len got %0d want %0d", n, DEPTH); end
    do_lookup(7'd127, 27'h5A5A5A5, 4'hF);
    checks++; if (rvalid_o !== 1'b1 || vbit_o !== 4'h0 || hit_o !== 1'b0) begin
      errors++; $display("FAIL fl_after got rv=%0b v=%h h=%0b want 1/0/0", rvalid_o, vbit_o, hit_o); end
  endtask

  task automatic test_flush_midwalk();
    int n;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n = 0;
    repeat (60) begin tick(); n++; end
    flush_i = 1'b1;
    tick(); n++;
    flush_i = 1'b0;
    while (ready_o !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL fl_ignore got %0d want %0d", n, DEPTH); end
  endtask

  task automatic test_reset_midwalk();
    int n;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (60) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n = 0;
    while (ready_o !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL rst_mid got %0d want %0d", n, DEPTH); end
    // Lookup accepted in the same cycle as reset must not produce a response.
    addr_i = 7'd9; cmp_tag_i = 27'h0ABCDEF; req_i = 4'hF; we_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; idle_in();
    checks++; if (rvalid_o !== 1'b0 || flush_busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_kill got rv=%0b busy=%0b want 0/1", rvalid_o, flush_busy_o); end
    n = 0;
    while (ready_o !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL rst_kill_len got %0d want %0d", n, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_write_hit();
    test_miss();
    test_multi_back_to_back();
    test_flush();
    test_flush_midwalk();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
